// File: rtl/fifo_unpacker.sv
// Read-side stage for the on-chip fifo: pops wide words and streams them out
// one OUT_WIDTH element per cycle, LSB element first, prefetching across words.
module fifo_unpacker #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    // IN_WIDTH must be an integer multiple of OUT_WIDTH.
    localparam int NUM_ELEM = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    logic                hold_valid;
    logic                shift_valid;
    logic [IN_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]    idx;
    logic                hs;
    logic                load;

    assign out_valid = shift_valid;
    assign out_data  = shreg[OUT_WIDTH-1:0];
    assign out_last  = shift_valid && (idx == LAST_IDX);
    assign busy      = hold_valid | shift_valid;

    assign hs   = out_valid && out_ready;
    // A held word moves into the shifter when it is empty or is draining its last element.
    assign load = hold_valid && (!shift_valid || (hs && out_last));

    // Popping in the load cycle keeps fifo_data one word ahead of the shifter.
    assign fifo_pop = !reset && !fifo_empty && (!hold_valid || load);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of load/hs/fifo_pop, never a half-updated mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (fifo_pop) begin
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // NOTE: the datapath register is reset too, so out_data reads zero after
    // reset instead of leaking the previous word's residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            idx         <= '0;
            shift_valid <= 1'b0;
        end else if (load) begin
            shreg       <= fifo_data;
            idx         <= '0;
            shift_valid <= 1'b1;
        end else if (hs) begin
            if (out_last) begin
                shift_valid <= 1'b0;
            end else begin
                shreg <= shreg >> OUT_WIDTH;
                idx   <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: a behavioural registered-read fifo
// feeds a 64/16 instance and a 32/32 instance; a scoreboard checks every handshake.
module tb_fifo_unpacker;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } elem_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [63:0] fifo_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    logic        fifo_empty1 = 1'b1;
    logic        fifo_pop1;
    logic [31:0] fifo_data1 = '0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [31:0] out_data1;
    logic        out_last1;
    logic        busy1;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int pop1_cnt = 0;

    logic [63:0] fq[$];
    logic [63:0] push_q[$];
    elem_t       exp_q[$];
    logic [31:0] fq1[$];
    logic [31:0] push1_q[$];
    logic [31:0] exp1_q[$];

    fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(32)) u_dut1 (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty1), .fifo_pop(fifo_pop1), .fifo_data(fifo_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic push_word(input logic [63:0] w);
        elem_t e;
        push_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            e.data = w[i*16 +: 16];
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_word1(input logic [31:0] w);
        push1_q.push_back(w);
        exp1_q.push_back(w);
    endtask

    // Registered-read fifo models sharing reset; pushes become visible one edge later.
    task automatic fifo_models();
        forever begin
            @(posedge clk);
            if (reset) begin
                fq.delete();  push_q.delete();
                fq1.delete(); push1_q.delete();
                fifo_data   <= '0;
                fifo_data1  <= '0;
                fifo_empty  <= 1'b1;
                fifo_empty1 <= 1'b1;
            end else begin
                if (fifo_pop) begin
                    checks++;
                    if (fq.size() == 0) begin
                        failures++;
                        $display("FAIL pop_on_empty got=pop exp=no_pop");
                    end else begin
                        fifo_data <= fq.pop_front();
                        pop_cnt++;
                    end
                end
                if (fifo_pop1) begin
                    checks++;
                    if (fq1.size() == 0) begin
                        failures++;
                        $display("FAIL pop1_on_empty got=pop exp=no_pop");
                    end else begin
                        fifo_data1 <= fq1.pop_front();
                        pop1_cnt++;
                    end
                end
                while (push_q.size() > 0) fq.push_back(push_q.pop_front());
                while (push1_q.size() > 0) fq1.push_back(push1_q.pop_front());
                fifo_empty  <= (fq.size() == 0);
                fifo_empty1 <= (fq1.size() == 0);
            end
        end
    endtask

    // Scoreboard: every handshake pops and compares the next expected element.
    task automatic monitor();
        elem_t       e;
        logic [31:0] e1;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        failures++;
                        $display("FAIL stream_elem got=%h/%b exp=%h/%b", out_data, out_last, e.data, e.last);
                    end
                end
            end
            if (!reset && out_valid1 && out_ready1) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream1_extra got=%h exp=none", out_data1);
                end else begin
                    e1 = exp1_q.pop_front();
                    if (out_data1 !== e1 || out_last1 !== 1'b1) begin
                        failures++;
                        $display("FAIL stream1_elem got=%h/%b exp=%h/1", out_data1, out_last1, e1);
                    end
                end
            end
        end
    endtask

    task automatic wait_first_valid(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_timeout got=no_valid exp=valid", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain got=%0d_left exp=0", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle got=%b%b exp=00", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_pop !== 1'b0 || out_data !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold got=%b%b%b/%h exp=000/0000", out_valid, busy, fifo_pop, out_data);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL idle got=%b%b%b%b exp=0000", fifo_pop, out_valid, busy, out_last);
            end
            checks++;
            if (fifo_pop1 !== 1'b0 || out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL idle1 got=%b%b%b exp=000", fifo_pop1, out_valid1, busy1);
            end
        end
    endtask

    task automatic test_single_word();
        int p0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        p0 = pop_cnt;
        push_word(64'h4444_3333_2222_1111);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fifo_pop === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL single_pop_timeout got=no_pop exp=pop");
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got=valid_at_t+1 exp=valid_at_t+2");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL single_stream cyc=%0d got=%b%b exp=10", i, out_valid, fifo_pop);
            end
            if (i == 0) begin
                checks++;
                if (out_data !== 16'h1111) begin
                    failures++;
                    $display("FAIL single_first got=%h exp=1111", out_data);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_end got=%b exp=0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (pop_cnt - p0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_pops got=%0d/%0d exp=1/0", pop_cnt - p0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        bit found;
        @(posedge clk); #1;
        out_ready = 1'b1;
        p0 = pop_cnt;
        push_word(64'hA3A3_A2A2_A1A1_A0A0);
        push_word(64'hB3B3_B2B2_B1B1_B0B0);
        push_word(64'hC3C3_C2C2_C1C1_C0C0);
        wait_first_valid("b2b", found);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_gap cyc=%0d got=%b exp=1", i, out_valid);
            end
            if (fifo_pop === 1'b1) begin
                checks++;
                if (out_ready !== 1'b1 || out_last !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_pop_align cyc=%0d got=last%b exp=last1", i, out_last);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_len got=valid_cycle13 exp=idle");
        end
        @(posedge clk); #1;
        checks++;
        if (pop_cnt - p0 != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pops got=%0d/%0d exp=3/0", pop_cnt - p0, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int p0;
        bit found = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        p0 = pop_cnt;
        push_word(64'h4444_3333_2222_1111);
        push_word(64'hDDDD_CCCC_BBBB_AAAA);
        push_word(64'h9999_8888_7777_6666);
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data === 16'h1111) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_start_timeout got=no_1111 exp=1111");
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_last !== 1'b0 || fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d got=%b/%h/%b/%b exp=1/2222/0/0",
                         i, out_valid, out_data, out_last, fifo_pop);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (pop_cnt - p0 != 3) begin
            failures++;
            $display("FAIL bp_pops got=%0d exp=3", pop_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_word();
        bit found = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_word(64'h4D4D_3C3C_2B2B_1A1A);
        push_word(64'h2020_2020_2020_2020);
        push_word(64'h3030_3030_3030_3030);
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data === 16'h2B2B) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_timeout got=no_2b2b exp=2b2b");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data !== 16'h3C3C || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got=%h/%b exp=3c3c/1", out_data, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_pop !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_clear got=%b%b%b/%h/%b exp=000/0000/0",
                     out_valid, busy, fifo_pop, out_data, out_last);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        push_word(64'h8888_7777_6666_5555);
        wait_first_valid("rst_restart", found);
        checks++;
        if (out_data !== 16'h5555) begin
            failures++;
            $display("FAIL rst_restart_elem0 got=%h exp=5555", out_data);
        end
        wait_drain("rst");
    endtask

    task automatic test_num_elem1();
        int p0;
        bit found = 1'b0;
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        p0 = pop1_cnt;
        push_word1(32'h0000_000A);
        push_word1(32'h0000_000B);
        push_word1(32'h0000_000C);
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (out_valid1 === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL ne1_timeout got=no_valid exp=valid");
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid1 !== 1'b1 || out_last1 !== 1'b1) begin
                failures++;
                $display("FAIL ne1_stream cyc=%0d got=%b%b exp=11", i, out_valid1, out_last1);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL ne1_end got=%b%b exp=00", out_valid1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (pop1_cnt - p0 != 3 || exp1_q.size() != 0) begin
            failures++;
            $display("FAIL ne1_pops got=%0d/%0d exp=3/0", pop1_cnt - p0, exp1_q.size());
        end
    endtask

    initial begin
        fork
            fifo_models();
            monitor();
        join_none
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_num_elem1();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
